// File: rtl/pipe_perf_monitor.sv
// ---------------------------------------------------------------------------
// pipe_perf_monitor
//   Performance/event monitor that sits beside the 5-stage pipeline. It counts
//   cycles spent running, load-use stalls, branch flushes and retired
//   instructions. It also records taken-branch target PCs in a small circular
//   trace buffer that debug logic can drain one entry per cycle.
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         asynchronous reset, active low
//   start_i       CPU running; enables counting
//   freeze_i      hold counters and trace for readout
//   clear_i       synchronous clear of counters, trace and flags (top priority)
//   stall_i       hazard-unit stall
//   branch_i      ID-stage Branch control bit (masks stall counting)
//   flush_i       branch taken, IF/ID flushed
//   retire_i      MEM/WB RegWrite
//   pc_i          current PC register value
//   cycle_cnt_o   cycles spent in RUN (saturating)
//   stall_cnt_o   stall events, stall_i & ~branch_i (saturating)
//   flush_cnt_o   flush events (saturating)
//   retire_cnt_o  retired instructions (saturating)
//   running_o     monitor is in RUN
//   trc_rd_i      pop request
//   trc_data_o    popped PC, valid while trc_valid_o is high
//   trc_valid_o   one-cycle pulse per successful pop
//   trc_empty_o   trace buffer empty
//   trc_full_o    trace buffer holds TRACE_DEPTH entries
//   trc_ovf_o     sticky: an unread entry was overwritten
// ---------------------------------------------------------------------------
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             freeze_i,
  input  logic             clear_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             running_o,
  input  logic             trc_rd_i,
  output logic [31:0]      trc_data_o,
  output logic             trc_valid_o,
  output logic             trc_empty_o,
  output logic             trc_full_o,
  output logic             trc_ovf_o
);

  localparam int PTR_W  = $clog2(TRACE_DEPTH);
  localparam int CNTR_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(1'b0);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNTR_W-1:0] OCC_ZERO = CNTR_W'(1'b0);
  localparam logic [CNTR_W-1:0] OCC_ONE  = CNTR_W'(1'b1);
  localparam logic [CNTR_W-1:0] OCC_FULL = CNTR_W'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Saturating increment: a counter that reached its maximum stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic              running_r;
  logic [CNT_W-1:0]  cycle_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [CNT_W-1:0]  retire_cnt_r;
  logic              wr_pend_r;

  logic [31:0]       mem_r [TRACE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNTR_W-1:0] occ_r;
  logic              empty_r;
  logic              full_r;
  logic              ovf_r;
  logic [31:0]       data_r;
  logic              valid_r;

  logic              run_s;
  logic              pop_s;
  logic              wr_s;
  logic              ovw_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [CNTR_W-1:0] occ_nxt_s;
  logic              ovf_nxt_s;

  // Next-state logic for IDLE/RUN/HALT; clear forces IDLE from anywhere.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (freeze_i || !start_i) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HALT: begin
          if (!freeze_i && start_i) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register; running flag is registered from the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Events are counted only on edges where the current state is RUN.
  assign run_s = (state_r == ST_RUN) && !clear_i;

  // Event counters, saturating, held outside RUN.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_r  <= CNT_ZERO;
      stall_cnt_r  <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
      retire_cnt_r <= CNT_ZERO;
    end else if (clear_i) begin
      cycle_cnt_r  <= CNT_ZERO;
      stall_cnt_r  <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
      retire_cnt_r <= CNT_ZERO;
    end else if (run_s) begin
      cycle_cnt_r <= sat_inc(cycle_cnt_r);
      if (stall_i && !branch_i) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_i) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
      if (retire_i) begin
        retire_cnt_r <= sat_inc(retire_cnt_r);
      end
    end
  end

  // A flush seen in RUN arms a write of the PC one cycle later, which is the
  // redirected branch target. The write completes even if RUN has just ended.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_pend_r <= 1'b0;
    end else if (clear_i) begin
      wr_pend_r <= 1'b0;
    end else begin
      wr_pend_r <= (state_r == ST_RUN) && flush_i;
    end
  end

  // Trace buffer bookkeeping: pop/write qualification, pointers, occupancy.
  // When full, a write without a pop overwrites the oldest entry by pushing
  // the read pointer forward along with the write pointer.
  always_comb begin
    pop_s        = 1'b0;
    wr_s         = 1'b0;
    ovw_s        = 1'b0;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    occ_nxt_s    = occ_r;
    ovf_nxt_s    = ovf_r;
    if (clear_i) begin
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
      occ_nxt_s    = OCC_ZERO;
      ovf_nxt_s    = 1'b0;
    end else begin
      pop_s = trc_rd_i && (occ_r != OCC_ZERO);
      wr_s  = wr_pend_r;
      ovw_s = wr_s && (occ_r == OCC_FULL) && !pop_s;
      if (pop_s || ovw_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (wr_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      case ({wr_s, pop_s})
        2'b10: begin
          if (occ_r == OCC_FULL) begin
            occ_nxt_s = occ_r;
          end else begin
            occ_nxt_s = occ_r + OCC_ONE;
          end
        end
        2'b01:   occ_nxt_s = occ_r - OCC_ONE;
        2'b11:   occ_nxt_s = occ_r;
        default: occ_nxt_s = occ_r;
      endcase
      ovf_nxt_s = ovf_r || ovw_s;
    end
  end

  // Trace pointer, occupancy and status-flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      occ_r    <= occ_nxt_s;
      empty_r  <= (occ_nxt_s == OCC_ZERO);
      full_r   <= (occ_nxt_s == OCC_FULL);
      ovf_r    <= ovf_nxt_s;
    end
  end

  // Trace storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= pc_i;
    end
  end

  // Pop result register. On a full+write+pop edge the read sees the old
  // oldest entry because the storage update is non-blocking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (clear_i) begin
      data_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else begin
      valid_r <= pop_s;
      if (pop_s) begin
        data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign cycle_cnt_o  = cycle_cnt_r;
  assign stall_cnt_o  = stall_cnt_r;
  assign flush_cnt_o  = flush_cnt_r;
  assign retire_cnt_o = retire_cnt_r;
  assign running_o    = running_r;
  assign trc_data_o   = data_r;
  assign trc_valid_o  = valid_r;
  assign trc_empty_o  = empty_r;
  assign trc_full_o   = full_r;
  assign trc_ovf_o    = ovf_r;

endmodule
